// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM encodings, master ids and the address window check.
package dmem_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic M_CPU = 1'b0;
  localparam logic M_IO  = 1'b1;

  localparam logic [23:0] IO_PAGE = 24'hffffff;

  // True when the byte address falls inside the RAM window (the I/O page never does).
  function automatic logic addr_in_window(input logic [31:0] addr, input int unsigned aw);
    return (addr[31:8] != IO_PAGE) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the pointer only matters when both masters request.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       winner_c,
  output logic       valid_c
);

  always_comb begin
    valid_c  = |req;
    winner_c = M_CPU;
    if (&req) begin
      winner_c = ptr;
    end else if (req[M_IO]) begin
      winner_c = M_IO;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU data port and the I/O loader,
// one access in flight at a time: IDLE -> ISSUE -> (WAIT -> RESP for reads) -> IDLE.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 3;

  logic [1:0]        state, state_n;
  logic              ptr, ptr_n;
  logic              win, win_n;
  logic              lat_we, lat_we_n;
  logic              in_range, in_range_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        gnt, gnt_n;
  logic [1:0]        err, err_n;
  logic [1:0]        rvalid, rvalid_n;
  logic [DATA_W-1:0] rdata0_n, rdata1_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic              mem_we_n;
  logic [DATA_W-1:0] mem_wdata_n;

  logic              arb_win_c, arb_valid_c;
  logic              sel_we, sel_in_range;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] cap;

  rr_arb2 u_rr (
    .req      ({m1_req, m0_req}),
    .ptr      (ptr),
    .winner_c (arb_win_c),
    .valid_c  (arb_valid_c)
  );

  // Next-state and next-output logic; every registered output is computed one cycle ahead.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    win_n       = win;
    lat_we_n    = lat_we;
    in_range_n  = in_range;
    cnt_n       = cnt;
    gnt_n       = 2'b00;
    err_n       = 2'b00;
    rvalid_n    = 2'b00;
    rdata0_n    = m0_rdata;
    rdata1_n    = m1_rdata;
    mem_addr_n  = mem_addr;
    mem_we_n    = 1'b0;
    mem_wdata_n = mem_wdata;

    sel_we       = (arb_win_c == M_IO) ? m1_we    : m0_we;
    sel_addr     = (arb_win_c == M_IO) ? m1_addr  : m0_addr;
    sel_wdata    = (arb_win_c == M_IO) ? m1_wdata : m0_wdata;
    sel_in_range = addr_in_window(sel_addr, ADDR_W);
    cap          = in_range ? mem_rdata : '0;

    case (state)
      S_IDLE: begin
        if (arb_valid_c) begin
          win_n            = arb_win_c;
          lat_we_n         = sel_we;
          in_range_n       = sel_in_range;
          mem_addr_n       = sel_addr[ADDR_W+1:2];
          mem_wdata_n      = sel_wdata;
          mem_we_n         = sel_we & sel_in_range;
          gnt_n[arb_win_c] = 1'b1;
          err_n[arb_win_c] = ~sel_in_range;
          state_n          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ptr_n = ~win;
        if (lat_we) begin
          state_n = S_IDLE;
        end else begin
          cnt_n   = CNT_W'(RD_LAT);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // The last WAIT cycle is ISSUE + RD_LAT, where the RAM data is valid.
        if (cnt <= CNT_W'(1)) begin
          cnt_n         = '0;
          rvalid_n[win] = 1'b1;
          if (win == M_IO) rdata1_n = cap;
          else             rdata0_n = cap;
          state_n       = S_RESP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= M_CPU;
      win       <= M_CPU;
      lat_we    <= 1'b0;
      in_range  <= 1'b0;
      cnt       <= '0;
      gnt       <= 2'b00;
      err       <= 2'b00;
      rvalid    <= 2'b00;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      win       <= win_n;
      lat_we    <= lat_we_n;
      in_range  <= in_range_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      err       <= err_n;
      rvalid    <= rvalid_n;
      m0_rdata  <= rdata0_n;
      m1_rdata  <= rdata1_n;
      mem_addr  <= mem_addr_n;
      mem_we    <= mem_we_n;
      mem_wdata <= mem_wdata_n;
    end
  end

  assign m0_gnt    = gnt[M_CPU];
  assign m1_gnt    = gnt[M_IO];
  assign m0_err    = err[M_CPU];
  assign m1_err    = err[M_IO];
  assign m0_rvalid = rvalid[M_CPU];
  assign m1_rvalid = rvalid[M_IO];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 3) share stimulus, each with its own RAM model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic        id;
    logic        err;
    logic        we;
    logic [4:0]  maddr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } rexp_t;

  logic clock;
  logic reset;
  logic ram_clr;

  logic          m0_req, m0_we, m1_req, m1_we;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_we;
  logic [31:0]   m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          m0_gnt_b, m0_rvalid_b, m0_err_b, m1_gnt_b, m1_rvalid_b, m1_err_b, mem_we_b;
  logic [31:0]   m0_rdata_b, m1_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [AW-1:0] mem_addr_b;

  logic [31:0] ram_a [32];
  logic [31:0] ram_b [32];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  gexp_t gq[$];
  rexp_t rq[$];
  int total = 0;
  int passed = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut_b (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b), .m0_rdata(m0_rdata_b), .m0_err(m0_err_b),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b), .m1_rdata(m1_rdata_b), .m1_err(m1_err_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // RAM models: synchronous write, read data valid RD_LAT cycles after the address is presented.
  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) begin
        ram_a[i] <= '0;
        ram_b[i] <= '0;
      end
      pipe_a    <= '0;
      pipe_b[0] <= '0;
      pipe_b[1] <= '0;
      pipe_b[2] <= '0;
    end else begin
      if (mem_we)   ram_a[mem_addr]   <= mem_wdata;
      if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
      pipe_a    <= ram_a[mem_addr];
      pipe_b[0] <= ram_b[mem_addr_b];
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
    end
  end
  assign mem_rdata   = pipe_a;
  assign mem_rdata_b = pipe_b[2];

  function automatic logic [107:0] outs_a();
    return {m0_gnt, m0_rvalid, m0_err, m0_rdata, m1_gnt, m1_rvalid, m1_err, m1_rdata,
            mem_addr, mem_we, mem_wdata};
  endfunction

  function automatic logic [107:0] outs_b();
    return {m0_gnt_b, m0_rvalid_b, m0_err_b, m0_rdata_b, m1_gnt_b, m1_rvalid_b, m1_err_b, m1_rdata_b,
            mem_addr_b, mem_we_b, mem_wdata_b};
  endfunction

  // Drive a request and push its expected grant (and read response) to the scoreboard.
  task automatic drive(input logic id, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd);
    gexp_t g;
    rexp_t r;
    g.id    = id;
    g.err   = (addr[31:AW+2] != '0);
    g.we    = we & ~g.err;
    g.maddr = addr[AW+1:2];
    g.wdata = wd;
    gq.push_back(g);
    if (!we) begin
      r.id   = id;
      r.data = g.err ? 32'd0 : rd;
      rq.push_back(r);
    end
    if (id) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end
  endtask

  // Wait (bounded) for the given master's grant on the latency-1 instance, then drop its request.
  task automatic wait_gnt(input logic id, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if ((id ? m1_gnt : m0_gnt) === 1'b1) begin
        cyc = i;
        if (id) m1_req = 1'b0;
        else    m0_req = 1'b0;
        break;
      end
    end
  endtask

  function automatic gexp_t pop_g();
    if (gq.size() != 0) return gq.pop_front();
    return '0;
  endfunction

  function automatic rexp_t pop_r();
    if (rq.size() != 0) return rq.pop_front();
    return '0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (outs_a() !== '0) $display("FAIL reset_outs_a got %h want 0", outs_a()); else passed++;
    total++; if (outs_b() !== '0) $display("FAIL reset_outs_b got %h want 0", outs_b()); else passed++;
    reset = 1'b0;
    @(negedge clock);
    total++; if (outs_a() !== '0) $display("FAIL idle_after_reset got %h want 0", outs_a()); else passed++;
  endtask

  task automatic test_write();
    gexp_t g;
    int cyc;
    drive(1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 32'h0);
    wait_gnt(1'b0, cyc);
    g = pop_g();
    total++; if (cyc !== 1) $display("FAIL wr_gnt_latency got %0d want 1", cyc); else passed++;
    total++; if ({mem_we, mem_addr, mem_wdata, m0_err, m1_gnt} !== {g.we, g.maddr, g.wdata, g.err, 1'b0})
      $display("FAIL wr_issue got %h want %h", {mem_we, mem_addr, mem_wdata, m0_err, m1_gnt},
               {g.we, g.maddr, g.wdata, g.err, 1'b0}); else passed++;
    total++; if ({m0_gnt_b, mem_we_b, mem_addr_b, mem_wdata_b} !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL wr_issue_b got %h want %h", {m0_gnt_b, mem_we_b, mem_addr_b, mem_wdata_b},
               {1'b1, 1'b1, 5'd5, 32'hDEADBEEF}); else passed++;
    @(negedge clock);
    total++; if ({m0_gnt, mem_we} !== 2'b00) $display("FAIL wr_after got %b want 00", {m0_gnt, mem_we}); else passed++;
  endtask

  task automatic test_read();
    gexp_t g;
    rexp_t r;
    int cyc, ca, cb;
    logic m0v;
    logic [31:0] da, db;
    drive(1'b1, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF);
    wait_gnt(1'b1, cyc);
    g = pop_g();
    r = pop_r();
    total++; if (cyc !== 1) $display("FAIL rd_gnt_latency got %0d want 1", cyc); else passed++;
    total++; if ({mem_we, mem_addr, m1_err, m0_gnt} !== {g.we, g.maddr, g.err, 1'b0})
      $display("FAIL rd_issue got %h want %h", {mem_we, mem_addr, m1_err, m0_gnt}, {g.we, g.maddr, g.err, 1'b0}); else passed++;
    ca = -1; cb = -1; m0v = 1'b0; da = '0; db = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (m0_rvalid || m0_rvalid_b) m0v = 1'b1;
      if (m1_rvalid && ca < 0) begin ca = i; da = m1_rdata; end
      if (m1_rvalid_b && cb < 0) begin cb = i; db = m1_rdata_b; end
    end
    total++; if (ca !== 2) $display("FAIL rd_rvalid_lat1 got %0d want 2", ca); else passed++;
    total++; if (cb !== 4) $display("FAIL rd_rvalid_lat3 got %0d want 4", cb); else passed++;
    total++; if (da !== r.data) $display("FAIL rd_data_lat1 got %h want %h", da, r.data); else passed++;
    total++; if (db !== r.data) $display("FAIL rd_data_lat3 got %h want %h", db, r.data); else passed++;
    total++; if (m0v !== 1'b0) $display("FAIL rd_m0_rvalid got %b want 0", m0v); else passed++;
    total++; if (m1_rdata !== r.data) $display("FAIL rd_data_hold got %h want %h", m1_rdata, r.data); else passed++;
  endtask

  task automatic test_contention();
    gexp_t g;
    int n, last;
    logic both;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n = 0; last = 0; both = 1'b0;
    drive(1'b0, 1'b1, 32'h00, 32'h1111_0000, 32'h0);
    drive(1'b1, 1'b1, 32'h40, 32'h2222_0001, 32'h0);
    for (int c = 1; c <= 20 && n < 4; c++) begin
      @(negedge clock);
      if (m0_gnt && m1_gnt) both = 1'b1;
      if (m0_gnt || m1_gnt) begin
        g = pop_g();
        total++; if (m1_gnt !== 1'(n % 2)) $display("FAIL rr_order[%0d] got m1_gnt=%b want %b", n, m1_gnt, 1'(n % 2)); else passed++;
        total++; if ({m1_gnt, mem_we, mem_addr, mem_wdata} !== {g.id, g.we, g.maddr, g.wdata})
          $display("FAIL rr_issue[%0d] got %h want %h", n, {m1_gnt, mem_we, mem_addr, mem_wdata},
                   {g.id, g.we, g.maddr, g.wdata}); else passed++;
        total++; if (c - last !== ((n == 0) ? 1 : 2)) $display("FAIL rr_spacing[%0d] got %0d want %0d", n, c - last, (n == 0) ? 1 : 2); else passed++;
        last = c;
        n++;
        if (m0_gnt) begin
          m0_req = 1'b0;
          if (n < 3) drive(1'b0, 1'b1, 32'h04, 32'h1111_0002, 32'h0);
        end
        if (m1_gnt) begin
          m1_req = 1'b0;
          if (n < 4) drive(1'b1, 1'b1, 32'h44, 32'h2222_0003, 32'h0);
        end
      end
    end
    total++; if (n !== 4) $display("FAIL rr_grant_count got %0d want 4", n); else passed++;
    total++; if (both !== 1'b0) $display("FAIL rr_double_gnt got %b want 0", both); else passed++;
    @(negedge clock);
  endtask

  task automatic test_out_of_range();
    logic        t_we   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_addr [7] = '{32'h00, 32'hffffff00, 32'h80, 32'h80, 32'h00, 32'h7C, 32'h7C};
    logic [31:0] t_wd   [7] = '{32'h0, 32'h0, 32'hBAD0BAD0, 32'h0, 32'h0, 32'h7C7C7C7C, 32'h0};
    logic [31:0] t_rd   [7] = '{32'h1111_0000, 32'h0, 32'h0, 32'h0, 32'h1111_0000, 32'h0, 32'h7C7C7C7C};
    gexp_t g;
    rexp_t r;
    int cyc, ca;
    logic we_seen;
    logic [31:0] da, db;
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, t_we[k], t_addr[k], t_wd[k], t_rd[k]);
      wait_gnt(1'b0, cyc);
      g = pop_g();
      total++; if (cyc !== 1) $display("FAIL oor_gnt_latency[%0d] got %0d want 1", k, cyc); else passed++;
      total++; if ({mem_we, mem_addr, m0_err, mem_we_b, m0_err_b} !== {g.we, g.maddr, g.err, g.we, g.err})
        $display("FAIL oor_issue[%0d] got %h want %h", k, {mem_we, mem_addr, m0_err, mem_we_b, m0_err_b},
                 {g.we, g.maddr, g.err, g.we, g.err}); else passed++;
      if (t_we[k]) begin
        @(negedge clock);
      end else begin
        r = pop_r();
        ca = -1; we_seen = 1'b0; da = '0; db = '0;
        for (int i = 1; i <= 6; i++) begin
          @(negedge clock);
          we_seen = we_seen | mem_we | mem_we_b;
          if (m0_rvalid && ca < 0) begin ca = i; da = m0_rdata; end
          if (m0_rvalid_b) db = m0_rdata_b;
        end
        total++; if (ca !== 2) $display("FAIL oor_rvalid[%0d] got %0d want 2", k, ca); else passed++;
        total++; if ({da, db} !== {r.data, r.data}) $display("FAIL oor_rdata[%0d] got %h want %h", k, {da, db}, {r.data, r.data}); else passed++;
        total++; if (we_seen !== 1'b0) $display("FAIL oor_mem_we[%0d] got %b want 0", k, we_seen); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, ca, cb;
    logic rv;
    logic [31:0] da, db;
    drive(1'b1, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF);
    wait_gnt(1'b1, cyc);
    total++; if (cyc !== 1) $display("FAIL rst_gnt_latency got %0d want 1", cyc); else passed++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total++; if (outs_b() !== '0) $display("FAIL rst_mid_outs_b got %h want 0", outs_b()); else passed++;
    total++; if (outs_a() !== '0) $display("FAIL rst_mid_outs_a got %h want 0", outs_a()); else passed++;
    reset = 1'b0;
    gq.delete();
    rq.delete();
    rv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      rv = rv | m1_rvalid | m1_rvalid_b | m0_rvalid | m0_rvalid_b;
    end
    total++; if (rv !== 1'b0) $display("FAIL rst_rvalid_dropped got %b want 0", rv); else passed++;
    drive(1'b1, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF);
    wait_gnt(1'b1, cyc);
    void'(pop_g());
    total++; if (cyc !== 1) $display("FAIL rst_regrant got %0d want 1", cyc); else passed++;
    ca = -1; cb = -1; da = '0; db = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (m1_rvalid && ca < 0) begin ca = i; da = m1_rdata; end
      if (m1_rvalid_b && cb < 0) begin cb = i; db = m1_rdata_b; end
    end
    void'(pop_r());
    total++; if ({ca, cb} !== {32'sd2, 32'sd4}) $display("FAIL rst_reread_lat got %0d/%0d want 2/4", ca, cb); else passed++;
    total++; if ({da, db} !== {32'hDEADBEEF, 32'hDEADBEEF}) $display("FAIL rst_reread_data got %h want deadbeefdeadbeef", {da, db}); else passed++;
    // An m0 grant leaves the pointer at m1; reset must return it to m0.
    drive(1'b0, 1'b1, 32'h08, 32'h0808_0808, 32'h0);
    wait_gnt(1'b0, cyc);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    gq.delete();
    drive(1'b0, 1'b1, 32'h0C, 32'h0C0C_0C0C, 32'h0);
    drive(1'b1, 1'b1, 32'h4C, 32'h4C4C_4C4C, 32'h0);
    wait_gnt(1'b0, cyc);
    total++; if ({cyc, m1_gnt} !== {32'sd1, 1'b0}) $display("FAIL rst_ptr_m0_first got cyc=%0d m1_gnt=%b want 1/0", cyc, m1_gnt); else passed++;
    wait_gnt(1'b1, cyc);
    total++; if (cyc !== 2) $display("FAIL rst_ptr_m1_next got %0d want 2", cyc); else passed++;
    gq.delete();
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    ram_clr = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(negedge clock);
    ram_clr = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_out_of_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
